// File: rtl/ram_pkg.sv
// Shared sizing and types for the MIPS data memory.
package ram_pkg;

    localparam int RAM_DATA_W = 32;
    localparam int RAM_ADDR_W = 10;
    localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;
    localparam int RAM_LANES  = RAM_DATA_W / 8;

    typedef logic [RAM_DATA_W-1:0] word_t;
    typedef logic [RAM_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/ram_module.sv
// Single-port word-addressed data memory, synchronous write / combinational tri-state read; optional byte enables via RAM_BYTE_WRITE_EN.
// Latency: write lands on the rising clk edge, read is 0 cycles from addr change.
// Backpressure: none; every strobed access completes, clr low blocks writes and floats data_out.
module ram_module
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              sel,
    input  logic              str,
    input  logic              ld,
`ifdef RAM_BYTE_WRITE_EN
    input  logic [DATA_W/8-1:0] be,
`endif
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // clr is the array's async reset, so a clear coinciding with a write edge always wins.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (sel && str) begin
`ifdef RAM_BYTE_WRITE_EN
            for (int b = 0; b < LANES; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= data_in[8*b +: 8];
                end
            end
`else
            mem[addr] <= data_in;
`endif
        end
    end

    // No write bypass: a same-address read shows the old word until the edge.
    assign data_out = (sel && ld && clr) ? mem[addr] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_module.sv
// Directed scoreboard bench for ram_module: stimulus queues expected reads, a monitor samples data_out on request.
module tb_ram_module;

    logic        clk;
    logic        clr;
    logic        sel;
    logic        str;
    logic        ld;
    logic [9:0]  addr;
    logic [31:0] data_in;
    wire  [31:0] data_out;
`ifdef RAM_BYTE_WRITE_EN
    logic [3:0]  be;
`endif

    ram_module dut (
        .clk      (clk),
        .clr      (clr),
        .sel      (sel),
        .str      (str),
        .ld       (ld),
`ifdef RAM_BYTE_WRITE_EN
        .be       (be),
`endif
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    typedef struct {
        logic [31:0] val;
        bit          want_z;
        string       name;
    } exp_t;

    exp_t exp_q [$];
    event sample_ev;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: each sample request pops one expectation and compares it to data_out.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_sample: got %h, no expectation queued", data_out);
            end else begin
                e = exp_q.pop_front();
                n_cmp++;
                if (e.want_z) begin
                    if (!(data_out === 32'hzzzz_zzzz)) begin
                        n_bad++;
                        $display("FAIL %s: got %h want zzzzzzzz", e.name, data_out);
                    end
                end else if (data_out !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: got %h want %h", e.name, data_out, e.val);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input logic [31:0] v, input bit z, input string nm);
        exp_t e;
        #1;
        e.val    = v;
        e.want_z = z;
        e.name   = nm;
        exp_q.push_back(e);
        ->sample_ev;
        #1;
    endtask

    task automatic read_chk(input logic [9:0] a, input logic [31:0] v, input string nm);
        sel  = 1'b1;
        ld   = 1'b1;
        str  = 1'b0;
        addr = a;
        expect_rd(v, 1'b0, nm);
    endtask

    task automatic write_word(input logic [9:0] a, input logic [31:0] d);
        sel     = 1'b1;
        str     = 1'b1;
        ld      = 1'b0;
        addr    = a;
        data_in = d;
`ifdef RAM_BYTE_WRITE_EN
        be      = 4'hF;
`endif
        step();
        str = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b0; sel = 1'b1; ld = 1'b1; str = 1'b0; addr = 10'd10; data_in = '0;
`ifdef RAM_BYTE_WRITE_EN
        be = 4'hF;
`endif
        step();
        expect_rd('0, 1'b1, "z_during_initial_clear");
        clr = 1'b1;
        step();
        read_chk(10'd10, 32'h0000_0000, "reset_state_addr10");

        step();
        write_word(10'd10, 32'hDEAD_BEEF);
        write_word(10'd20, 32'hCAFE_BABE);
        read_chk(10'd10, 32'hDEAD_BEEF, "read_addr10");
        read_chk(10'd20, 32'hCAFE_BABE, "read_addr20");

        step();
        sel = 1'b0; ld = 1'b1; addr = 10'd20;
        expect_rd('0, 1'b1, "z_sel0");
        sel = 1'b1; ld = 1'b0;
        expect_rd('0, 1'b1, "z_ld0");

        step();
        sel = 1'b1; ld = 1'b1; addr = 10'd10;
        clr = 1'b0;
        expect_rd('0, 1'b1, "z_during_reclear");
        #8;
        clr = 1'b1;
        read_chk(10'd10, 32'h0000_0000, "reclear_addr10");
        read_chk(10'd1023, 32'h0000_0000, "reclear_addr1023");

        step();
        sel = 1'b0; str = 1'b1; ld = 1'b0; addr = 10'd5; data_in = 32'h1234_5678;
        step();
        str = 1'b0;
        read_chk(10'd5, 32'h0000_0000, "no_write_when_sel0");

        step();
        write_word(10'd1023, 32'hA5A5_A5A5);
        read_chk(10'd0, 32'h0000_0000, "no_alias_addr0");
        read_chk(10'd1023, 32'hA5A5_A5A5, "read_addr1023");

        step();
        write_word(10'd7, 32'h1111_1111);
        sel = 1'b1; ld = 1'b1; str = 1'b1; addr = 10'd7; data_in = 32'h2222_2222;
        expect_rd(32'h1111_1111, 1'b0, "rdw_old_before_edge");
        step();
        expect_rd(32'h2222_2222, 1'b0, "rdw_new_after_edge");
        str = 1'b0;

        step();
        sel = 1'b1; str = 1'b1; ld = 1'b0; addr = 10'd9; data_in = 32'h3333_3333;
        clr = 1'b0;
        step();
        str = 1'b0;
        clr = 1'b1;
        read_chk(10'd9, 32'h0000_0000, "clear_wins_over_write");
        read_chk(10'd7, 32'h0000_0000, "clear_wipes_addr7");

`ifdef RAM_BYTE_WRITE_EN
        step();
        write_word(10'd3, 32'hAABB_CCDD);
        sel = 1'b1; str = 1'b1; ld = 1'b0; addr = 10'd3; data_in = 32'h1122_3344; be = 4'b0101;
        step();
        str = 1'b0;
        read_chk(10'd3, 32'hAA22_CC44, "byte_enable_0101");
        step();
        sel = 1'b1; str = 1'b1; ld = 1'b0; addr = 10'd3; data_in = 32'hFFFF_FFFF; be = 4'b0000;
        step();
        str = 1'b0;
        read_chk(10'd3, 32'hAA22_CC44, "byte_enable_none");
`endif

        step();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_module.md
Name: ram_module

Overview:
- Single-port 1024 x 32-bit data memory for the single-cycle MIPS datapath.
- Writes are synchronous and gated by chip-select plus store strobe.
- Reads are combinational and gated by chip-select plus load strobe; the output is tri-stated when not reading.
- Whole-array asynchronous clear for simulation/boot.

Parameters:
- DATA_W, 32, word width in bits
- ADDR_W, 10, word-address width
- DEPTH, 1<<ADDR_W (1024), number of words (derived, not overridable)

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous, active-low clear of the entire array
- sel  input  1  chip select; the block ignores str/ld when 0
- str  input  1  store strobe
- ld  input  1  load strobe
- addr  input  ADDR_W  word address (not byte address)
- data_in  input  DATA_W  write data
- data_out  output  DATA_W  read data; high-Z when not driven

Behaviour:
- Storage: DEPTH words of DATA_W bits.
- Clear: while clr=0, every word is forced to 0 immediately, independent of clk; writes are blocked. After clr deasserts, all words read 0 until written.
- Write: on rising clk with clr=1, sel=1 and str=1, mem[addr] <= data_in. No write in any other case.
- Read: combinational. data_out = mem[addr] when sel=1 and ld=1 and clr=1. Otherwise data_out = all Z (including during clear).
- Read latency: 0 cycles from addr change.
- Read-during-write, same address (sel=ld=str=1): data_out shows the old word until the clock edge, then the new word in the same cycle after the edge. No bypass.
- The full addr range is valid; no wrap or out-of-range case exists because DEPTH = 2^ADDR_W.
- clr asserted mid-write cycle: the clear wins; the word stays 0.
- No other state; no outputs besides data_out.

Optional Feature:
- Macro: RAM_BYTE_WRITE_EN.
- Defined:
  - Adds input be, width DATA_W/8 (4).
  - On a write, only bytes with be[i]=1 are updated (byte i = bits 8i+7:8i); other bytes are retained.
  - be=0 with str=1 writes nothing.
- Undefined:
  - No be port.
  - Every write updates the full word.
- Reads and clear are identical in both builds.

Decomposition:
- Shared package (ram_pkg): DATA_W/ADDR_W defaults, DEPTH constant, word_t and addr_t typedefs, byte-lane count constant.
- No sub-module needed. Optionally a one-level byte-lane write helper, ram_byte_lane, instantiated per lane only under RAM_BYTE_WRITE_EN.
- Storage array, write process and tri-state read mux live in ram_module.

Test Plan:
- Clear then write:
  - Pulse clr=0 for 1 cycle, then sel=1, str=1, write addr 10=0xDEADBEEF and addr 20=0xCAFEBABE on consecutive edges.
  - Then str=0, ld=1: addr 10 -> data_out=0xDEADBEEF; addr 20 -> data_out=0xCAFEBABE.
- Deselect: sel=0, ld=1, addr=20 -> data_out=ZZZZZZZZ.
- Also with sel=1, ld=0 -> data_out=Z.
- Re-clear:
  - After the writes above, clr=0 for 10 ns, then clr=1, sel=1, ld=1.
  - addr 10 -> 0x00000000; addr 1023 -> 0x00000000.
  - During clr=0, data_out=Z.
- Write gating:
  - sel=0, str=1, data_in=0x12345678 at addr 5 -> subsequent read of addr 5 returns 0x00000000.
  - Write at addr 1023=0xA5A5A5A5, read addr 0 -> 0 (no aliasing).
- Read-during-write:
  - addr 7 holds 0x11111111; sel=ld=str=1, data_in=0x22222222.
  - Before the edge, data_out=0x11111111; after the edge, 0x22222222.
- RAM_BYTE_WRITE_EN build:
  - addr 3 holds 0xAABBCCDD; write 0x11223344 with be=4'b0101.
  - Read addr 3 -> 0xAA22CC44.
